// File: rtl/irq_request_latch.sv
// -----------------------------------------------------------------------------
// irq_request_latch
//   Request-capture stage that feeds a priority encoder. Each raw asynchronous
//   request line goes through its own synchroniser. The block then detects an
//   event on the line: a rising edge, or simply a high level when edge
//   detection is off. Each event is held as a pending bit until the consumer
//   acknowledges that bit's index. The masked pending vector and its OR-reduce
//   drive the encoder's D/en inputs directly.
//
// Parameters
//   N_REQ        number of request lines (>= 2)
//   SYNC_STAGES  synchroniser depth per line (2 or 3)
//   EDGE_MODE    1 = rising-edge capture, 0 = level capture
//
// Ports
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   req_in    raw asynchronous request lines
//   mask      1 hides a bit from D/en; the pending state is kept
//   ack       one-cycle pulse: request ack_id has been serviced
//   ack_id    index being acknowledged (encoder y output)
//   ovf_clr   clears all overflow flags
//   D         pending & ~mask, to the encoder D input
//   en        |D, to the encoder enable
//   pending   raw pending register
//   overflow  sticky per-bit flag: an edge arrived while the bit was pending
// -----------------------------------------------------------------------------
module irq_request_latch #(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_MODE   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_in,
  input  logic [N_REQ-1:0]         mask,
  input  logic                     ack,
  input  logic [$clog2(N_REQ)-1:0] ack_id,
  input  logic                     ovf_clr,
  output logic [N_REQ-1:0]         D,
  output logic                     en,
  output logic [N_REQ-1:0]         pending,
  output logic [N_REQ-1:0]         overflow
);

  localparam int AW = $clog2(N_REQ);

  logic [SYNC_STAGES-1:0][N_REQ-1:0] sync_q, sync_d;
  logic [N_REQ-1:0] prev_q, prev_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [N_REQ-1:0] overflow_q, overflow_d;
  logic [N_REQ-1:0] s;
  logic [N_REQ-1:0] ev;
  logic [N_REQ-1:0] clr;
  logic [N_REQ-1:0] ovf_set;

  // Synchroniser chain: stage 0 samples the raw lines, and the last stage is
  // the first value that is safe to use.
  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = req_in;
    for (int st = 1; st < SYNC_STAGES; st++) begin
      sync_d[st] = sync_q[st-1];
    end
  end

  assign s      = sync_q[SYNC_STAGES-1];
  assign prev_d = s;

  always_comb begin
    ev = '0;
    if (EDGE_MODE) begin
      ev = s & ~prev_q;
    end else begin
      ev = s;
    end
  end

  // An ack_id outside 0..N_REQ-1 matches no bit, so it is ignored.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      clr[i] = ack && (ack_id == AW'(i));
    end
  end

  // The set term has priority over the clear term, so an event that arrives
  // in the same cycle as its ack is kept. In level mode this means that an
  // ack on a line that is still high is immediately undone by the level.
  assign pending_d = (pending_q & ~clr) | ev;

  // An edge only counts as lost when it lands on a bit that is pending and
  // is not being cleared in that same cycle. A new set has priority over
  // ovf_clr.
  always_comb begin
    ovf_set = '0;
    if (EDGE_MODE) begin
      ovf_set = ev & pending_q & ~clr;
    end
  end

  assign overflow_d = (ovf_clr ? '0 : overflow_q) | ovf_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      prev_q     <= '0;
      pending_q  <= '0;
      overflow_q <= '0;
    end else begin
      sync_q     <= sync_d;
      prev_q     <= prev_d;
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  // D is combinational from the mask so that unmasking takes effect at once.
  assign D        = pending_q & ~mask;
  assign en       = |D;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_irq_request_latch.sv
module tb_irq_request_latch;

  logic       clk;
  logic       rst;
  logic [3:0] req_in, mask;
  logic       ack, ovf_clr;
  logic [1:0] ack_id;
  logic [3:0] d_o, pend_o, ovf_o;
  logic       en_o;

  logic [3:0] req_l, mask_l;
  logic       ack_l, ovf_clr_l;
  logic [1:0] ack_id_l;
  logic [3:0] d_l, pend_l, ovf_l;
  logic       en_l;

  int n_chk = 0;
  int n_err = 0;

  irq_request_latch #(.N_REQ(4), .SYNC_STAGES(2), .EDGE_MODE(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_in(req_in), .mask(mask), .ack(ack),
    .ack_id(ack_id), .ovf_clr(ovf_clr), .D(d_o), .en(en_o),
    .pending(pend_o), .overflow(ovf_o)
  );

  irq_request_latch #(.N_REQ(4), .SYNC_STAGES(2), .EDGE_MODE(1'b0)) u_lvl (
    .clk(clk), .rst(rst), .req_in(req_l), .mask(mask_l), .ack(ack_l),
    .ack_id(ack_id_l), .ovf_clr(ovf_clr_l), .D(d_l), .en(en_l),
    .pending(pend_l), .overflow(ovf_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; req_in = 4'hF; mask = 4'h0; ack = 1'b0; ack_id = 2'd0; ovf_clr = 1'b0;
    req_l = 4'h0; mask_l = 4'h0; ack_l = 1'b0; ack_id_l = 2'd0; ovf_clr_l = 1'b0;

    // Reset held with every line high.
    step(2);
    chk("rst_D", d_o, 4'h0);
    chk("rst_en", {3'b0, en_o}, 4'h0);
    chk("rst_ovf", ovf_o, 4'h0);
    chk("rst_pend", pend_o, 4'h0);
    rst = 1'b0;
    step(2);
    chk("rel_pend_2edges", pend_o, 4'h0);
    step(1);
    chk("rel_pend_3edges", pend_o, 4'hF);
    step(3);
    chk("rel_pend_once", pend_o, 4'hF);
    chk("rel_ovf_none", ovf_o, 4'h0);

    // Drain every bit by acknowledging it.
    req_in = 4'h0;
    ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ack_id = 2'(i);
      step(1);
    end
    ack = 1'b0;
    chk("drain_pend", pend_o, 4'h0);
    chk("drain_en", {3'b0, en_o}, 4'h0);

    // Basic capture and ack.
    req_in = 4'b0100;
    step(2);
    chk("cap_D_2edges", d_o, 4'h0);
    step(1);
    chk("cap_D", d_o, 4'b0100);
    chk("cap_en", {3'b0, en_o}, 4'h1);
    ack = 1'b1; ack_id = 2'd2;
    step(1);
    ack = 1'b0;
    chk("ack_D", d_o, 4'h0);
    chk("ack_en", {3'b0, en_o}, 4'h0);

    // Mask behaviour, checked between clock edges.
    req_in = 4'b1010;
    step(3);
    chk("mask_pend", pend_o, 4'b1010);
    mask = 4'b1000;
    #1;
    chk("mask_D", d_o, 4'b0010);
    mask = 4'b0000;
    #1;
    chk("unmask_D", d_o, 4'b1010);
    chk("unmask_pend", pend_o, 4'b1010);
    mask = 4'hF;
    #1;
    chk("maskall_en", {3'b0, en_o}, 4'h0);
    ack = 1'b1; ack_id = 2'd3;
    step(1);
    ack = 1'b0;
    chk("ack_masked_pend", pend_o, 4'b0010);
    mask = 4'h0;
    #1;
    chk("ack_masked_D", d_o, 4'b0010);
    ack = 1'b1; ack_id = 2'd1;
    step(1);
    ack = 1'b0;
    chk("ack1_pend", pend_o, 4'h0);

    // A new edge in the same cycle as the ack of that bit keeps the bit set.
    req_in = 4'h0;
    step(3);
    req_in = 4'b0010;
    step(3);
    chk("race_pre_pend", pend_o, 4'b0010);
    req_in = 4'h0;
    step(3);
    req_in = 4'b0010;
    step(2);
    ack = 1'b1; ack_id = 2'd1;
    step(1);
    ack = 1'b0;
    chk("race_pend", pend_o, 4'b0010);
    chk("race_ovf", ovf_o, 4'h0);
    ack = 1'b1; ack_id = 2'd1;
    step(1);
    ack = 1'b0;
    chk("race_cleanup", pend_o, 4'h0);

    // Overflow on a second edge while the bit is pending.
    req_in = 4'h0;
    step(3);
    req_in = 4'b0001;
    step(3);
    chk("ovf_pre_pend", pend_o, 4'b0001);
    chk("ovf_pre_ovf", ovf_o, 4'h0);
    req_in = 4'h0;
    step(2);
    req_in = 4'b0001;
    step(3);
    chk("ovf_set", ovf_o, 4'b0001);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_clr", ovf_o, 4'h0);
    chk("ovf_clr_pend", pend_o, 4'b0001);

    // Acks that do not hit a pending bit change nothing.
    ack = 1'b1; ack_id = 2'd3;
    step(1);
    ack_id = 2'd2;
    step(1);
    ack = 1'b0;
    chk("bogus_pend", pend_o, 4'b0001);
    chk("bogus_ovf", ovf_o, 4'h0);

    // An overflow set in the same cycle as ovf_clr takes priority.
    req_in = 4'h0;
    step(3);
    req_in = 4'b0001;
    step(2);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", ovf_o, 4'b0001);

    // Mid-operation reset discards state asynchronously.
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_pend", pend_o, 4'h0);
    chk("async_rst_ovf", ovf_o, 4'h0);
    step(1);
    rst = 1'b0;
    // The line is still high, so it is captured once after release.
    step(3);
    chk("restart_pend", pend_o, 4'b0001);
    chk("restart_ovf", ovf_o, 4'h0);

    // Level mode: a held line re-sets pending through its ack.
    req_l = 4'b0010;
    step(3);
    chk("lvl_pend", pend_l, 4'b0010);
    ack_l = 1'b1; ack_id_l = 2'd1;
    step(1);
    ack_l = 1'b0;
    chk("lvl_ack_held", pend_l, 4'b0010);
    chk("lvl_ovf", ovf_l, 4'h0);
    req_l = 4'h0;
    step(2);
    ack_l = 1'b1; ack_id_l = 2'd1;
    step(1);
    ack_l = 1'b0;
    chk("lvl_ack_low", pend_l, 4'h0);
    step(1);
    chk("lvl_stays_low", pend_l, 4'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
